// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned MD_LATENCY_MIN = 2;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    // One bundle for every stall/flush/done strobe the controller drives.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic md_done;
    } hazard_out_t;

    // Elaboration-time legality of the mul/div latency.
    function automatic bit md_latency_ok(input int lat);
        return (lat >= int'(MD_LATENCY_MIN));
    endfunction

    // Strobes while a mul/div op is still computing: freeze F/D/E, bubble into M.
    function automatic hazard_out_t md_stall_terms();
        hazard_out_t o;
        o         = '0;
        o.stall_f = 1'b1;
        o.stall_d = 1'b1;
        o.stall_e = 1'b1;
        o.flush_m = 1'b1;
        return o;
    endfunction

    // Branch/load-use strobes; a taken branch squashes D, so it beats load-use.
    function automatic hazard_out_t hazard_terms(input logic br, input logic lu);
        hazard_out_t o;
        o = '0;
        if (br) begin
            o.flush_d = 1'b1;
            o.flush_e = 1'b1;
        end else if (lu) begin
            o.stall_f = 1'b1;
            o.stall_d = 1'b1;
            o.flush_e = 1'b1;
        end else begin
            o = '0;
        end
        return o;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard-controller bundle: pipeline register/hazard inputs and stall/flush outputs.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [4:0]       rdE;
    logic             memReadE;
    logic             pcSrcE;
    logic             mdStartE;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             flushD;
    logic             flushE;
    logic             flushM;
    logic             mdDone;
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;

    // Pipeline side: supplies hazard inputs, consumes stall/flush controls.
    modport master (
        output rs1D, rs2D, rdE, memReadE, pcSrcE, mdStartE,
        input  stallF, stallD, stallE, flushD, flushE, flushM, mdDone,
        input  stallCount, flushCount
    );

    // Controller side.
    modport slave (
        input  rs1D, rs2D, rdE, memReadE, pcSrcE, mdStartE,
        output stallF, stallD, stallE, flushD, flushE, flushM, mdDone,
        output stallCount, flushCount
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: step only when requested and not already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and
// multi-cycle mul/div holds for the 5-stage core, plus perf counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_controller_if.slave hz
);
    localparam int CW = $clog2(MD_LATENCY);
    localparam logic [CW-1:0] CNT_INIT = CW'(MD_LATENCY - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (!md_latency_ok(MD_LATENCY)) begin : g_bad_md_latency
        $error("hazard_controller: MD_LATENCY must be at least 2");
    end

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    hazard_out_t   out_s;
    logic          lu_s;
    logic          br_flush_s;

    // Hazard decode and next-state: outputs are combinational so the pipeline reacts in-cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_s      = '0;
        br_flush_s = 1'b0;
        lu_s       = hz.memReadE && (hz.rdE != 5'd0) &&
                     ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
        if (rst) begin
            out_s   = '0;
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.mdStartE) begin
                        // E holds a mul/div, so lu and pcSrcE do not apply.
                        out_s   = md_stall_terms();
                        state_d = MD_BUSY;
                        cnt_d   = CNT_INIT;
                    end else begin
                        out_s      = hazard_terms(hz.pcSrcE, lu_s);
                        br_flush_s = hz.pcSrcE;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q != '0) begin
                        out_s = md_stall_terms();
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        // Result ready; mdStartE still belongs to this op, so it is ignored.
                        out_s         = hazard_terms(hz.pcSrcE, lu_s);
                        out_s.md_done = 1'b1;
                        br_flush_s    = hz.pcSrcE;
                        state_d       = RUN;
                    end
                end
                default: begin
                    out_s   = '0;
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state and mul/div down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.stallF = out_s.stall_f;
    assign hz.stallD = out_s.stall_d;
    assign hz.stallE = out_s.stall_e;
    assign hz.flushD = out_s.flush_d;
    assign hz.flushE = out_s.flush_e;
    assign hz.flushM = out_s.flush_m;
    assign hz.mdDone = out_s.md_done;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_s.stall_f),
        .count (hz.stallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_flush_s),
        .count (hz.flushCount)
    );

endmodule
